shift_rotate_pipe: RTL and testbench
====================================

Name: shift_rotate_pipe

Overview:
- Parametrised, pipelined successor to the team's 32-bit combinational rotate-right unit.
- Performs rotate-right, rotate-left, logical-right and arithmetic-right on a WIDTH-bit operand.
- Provides valid/ready handshakes on both sides, per-stage bubble collapsing, a shifted-out (carry) flag and a zero flag.
- Sits between the ALU operand-select logic and the ALU result mux; sustains one operation per cycle.

Parameters:
- WIDTH, 32: operand width; must be a power of two, >= 8. Derived localparam SW = log2(WIDTH).
- PIPE, 2: number of register stages, 1..SW; latency in cycles from acceptance to out_valid.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; invalidates every stage.
- in_valid  input  1  operand/command valid.
- in_ready  output  1  stage 0 can accept.
- in  input  WIDTH  operand.
- num  input  SW  shift/rotate amount.
- mode  input  2  00 ROR, 01 ROL, 10 SRL, 11 SRA.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- out_carry  output  1  last bit shifted/rotated out.
- out_zero  output  1  out == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out, out_carry and out_zero are 0. in_ready is 1 once rst_n is high.
- Datapath:
  - SW log levels; level k shifts by 2^k when num[k] is set.
  - The registered stage boundary falls after every ceil(SW/PIPE) levels; the final boundary drives out.
  - Each stage carries mode, remaining num bits, the running carry and the sign bit (in[WIDTH-1], captured at stage 0).
- Mode semantics:
  - ROR: out = in rotated right by num.
  - ROL: out = in rotated left by num.
  - SRL: zero fill.
  - SRA: fill with the captured sign.
  - num = 0 in any mode: out = in, out_carry = 0.
- Carry (num != 0):
  - ROR: out[WIDTH-1].
  - ROL: out[0].
  - SRL/SRA: in[num-1].
- out_zero is computed combinationally from the final data register.
- Handshake:
  - Transfer on a side occurs when valid and ready are both high in the same cycle.
  - Stage i advances when it is empty or stage i+1 advances; the last stage advances when out_valid is 0 or out_ready is 1.
  - in_ready = stage-0 advance condition. Bubbles collapse.
  - While out_valid=1 and out_ready=0, out, out_carry and out_zero are held stable.
  - Latency is exactly PIPE cycles with no stall; throughput is 1/cycle with out_ready held high.
- Capacity: at most PIPE results in flight; in_ready drops only when all stages are full and the output is stalled.
- Simultaneous events:
  - Output pop and input push in the same cycle both occur.
  - flush has priority over any push: all valids clear next cycle, and an input presented in the flush cycle is dropped even if in_ready=1.
- Reset mid-operation: all in-flight results are discarded immediately; no partial output appears after release.
- Inputs are sampled only on an accepted transfer; X on in, num or mode with in_valid=0 must not propagate.

Test Plan:
- WIDTH=32, PIPE=2. ROR in=0x8000_0001 num=1 -> out=0xC000_0000, carry=1, zero=0, out_valid exactly 2 cycles after accept.
- ROL in=0x8000_0001 num=4 -> out=0x0000_0018, carry=0. SRL in=0xF000_000F num=4 -> out=0x0F00_0000, carry=1. SRA in=0x8000_0000 num=31 -> out=0xFFFF_FFFF, carry=0. SRL in=0x0000_0001 num=1 -> out=0, carry=1, zero=1.
- num=0 in all four modes with in=0xDEAD_BEEF -> out=0xDEAD_BEEF, carry=0.
- Hold out_ready=0 and offer 3 back-to-back ops -> 2 accepted, in_ready=0 on the third, out stable; release out_ready -> results in issue order, third op accepted the same cycle.
- Stream 64 random ops with out_ready=1 -> one result per cycle, all matching the reference model. Repeat with random out_ready at 50% -> no loss, no duplication, order preserved.
- Assert rst_n low with 2 ops in flight -> out_valid=0 and out=0 immediately. Assert flush with 2 in flight plus an input offered -> out_valid=0 next cycle and no result ever emerges for the 3 ops.

Source files
------------

// File: rtl/shift_rotate_pipe.sv
// shift_rotate_pipe: pipelined ROR/ROL/SRL/SRA unit with valid/ready on both sides,
// carry (last bit out) and zero flags; log shifter levels are split evenly across PIPE stages.
module shift_rotate_pipe #(
  parameter int WIDTH = 32,
  parameter int PIPE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in,
  input  logic [$clog2(WIDTH)-1:0] num,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     out_carry,
  output logic                     out_zero
);
  localparam int SW = $clog2(WIDTH);
  localparam int LPS = (SW + PIPE - 1) / PIPE;
  localparam logic [WIDTH-1:0] ONES = '1;
  logic             v_q     [PIPE];
  logic             v_d     [PIPE];
  logic [WIDTH-1:0] data_q  [PIPE];
  logic [WIDTH-1:0] data_d  [PIPE];
  logic [SW-1:0]    num_q   [PIPE];
  logic [SW-1:0]    num_d   [PIPE];
  logic [1:0]       mode_q  [PIPE];
  logic [1:0]       mode_d  [PIPE];
  logic             carry_q [PIPE];
  logic             carry_d [PIPE];
  logic             sign_q  [PIPE];
  logic             sign_d  [PIPE];
  logic             src_v     [PIPE];
  logic [WIDTH-1:0] src_data  [PIPE];
  logic [SW-1:0]    src_num   [PIPE];
  logic [1:0]       src_mode  [PIPE];
  logic             src_carry [PIPE];
  logic             src_sign  [PIPE];
  logic [PIPE:0]    adv;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] nd;
  logic [WIDTH-1:0] lsb;
  logic             c;
  logic             ld;
  int               sh;
  always_comb begin
    adv[PIPE] = out_ready;
    for (int s = PIPE - 1; s >= 0; s--) adv[s] = !v_q[s] || adv[s + 1];
    src_v[0] = in_valid;
    src_data[0] = in;
    src_num[0] = num;
    src_mode[0] = mode;
    src_carry[0] = 1'b0;
    src_sign[0] = in[WIDTH-1];
    for (int s = 1; s < PIPE; s++) begin
      src_v[s] = v_q[s-1];
      src_data[s] = data_q[s-1];
      src_num[s] = num_q[s-1];
      src_mode[s] = mode_q[s-1];
      src_carry[s] = carry_q[s-1];
      src_sign[s] = sign_q[s-1];
    end
    d = '0;
    nd = '0;
    lsb = '0;
    c = 1'b0;
    ld = 1'b0;
    sh = 0;
    for (int s = 0; s < PIPE; s++) begin
      d = src_data[s];
      c = src_carry[s];
      // level k belongs to stage k/LPS; the running carry is the last bit pushed out
      for (int k = 0; k < SW; k++) begin
        sh = 1 << k;
        if (k / LPS == s && src_num[s][k]) begin
          lsb = d >> (sh - 1);
          nd = src_mode[s] == 2'b00 ? (d >> sh) | (d << (WIDTH - sh)) :
               src_mode[s] == 2'b01 ? (d << sh) | (d >> (WIDTH - sh)) :
               (d >> sh) | (src_mode[s][0] && src_sign[s] ? ~(ONES >> sh) : '0);
          c = src_mode[s] == 2'b00 ? nd[WIDTH-1] : src_mode[s] == 2'b01 ? nd[0] : lsb[0];
          d = nd;
        end
      end
      ld = adv[s] && src_v[s];
      v_d[s] = !flush && (adv[s] ? src_v[s] : v_q[s]);
      data_d[s] = ld ? d : data_q[s];
      num_d[s] = ld ? src_num[s] : num_q[s];
      mode_d[s] = ld ? src_mode[s] : mode_q[s];
      carry_d[s] = ld ? c : carry_q[s];
      sign_d[s] = ld ? src_sign[s] : sign_q[s];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < PIPE; s++) begin
        v_q[s] <= 1'b0;
        data_q[s] <= '0;
        num_q[s] <= '0;
        mode_q[s] <= '0;
        carry_q[s] <= 1'b0;
        sign_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < PIPE; s++) begin
        v_q[s] <= v_d[s];
        data_q[s] <= data_d[s];
        num_q[s] <= num_d[s];
        mode_q[s] <= mode_d[s];
        carry_q[s] <= carry_d[s];
        sign_q[s] <= sign_d[s];
      end
    end
  assign in_ready = adv[0];
  assign out_valid = v_q[PIPE-1];
  assign out = data_q[PIPE-1];
  assign out_carry = carry_q[PIPE-1];
  assign out_zero = out_valid && ~|out;
endmodule

// File: tb/tb_shift_rotate_pipe.sv
// tb_shift_rotate_pipe: scoreboard bench for shift_rotate_pipe (WIDTH=32, PIPE=2)
module tb_shift_rotate_pipe;
  localparam int W = 32;
  localparam int SW = 5;
  typedef struct packed {
    logic [W-1:0] d;
    logic         c;
    logic         z;
  } res_t;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [W-1:0] din = '0;
  logic [SW-1:0] num = '0;
  logic [1:0] mode = '0;
  logic out_valid;
  logic out_ready = 0;
  logic [W-1:0] out;
  logic out_carry;
  logic out_zero;
  int checks = 0;
  int errors = 0;
  int popped = 0;
  bit rnd_en = 0;
  res_t exp_q[$];
  res_t e;

  shift_rotate_pipe #(.WIDTH(W), .PIPE(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in(din), .num(num), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_carry(out_carry), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  always @(posedge clk) if (rnd_en) begin
    #1;
    out_ready = 1'($urandom_range(0, 1));
  end

  // scoreboard: a transfer happens at the next posedge when valid and ready are both high now
  always @(negedge clk) if (rst_n && out_valid && out_ready) begin
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_out got %h carry %b zero %b, queue empty", out, out_carry, out_zero);
    end else begin
      e = exp_q.pop_front();
      popped++;
      if ({out, out_carry, out_zero} !== e) begin
        errors++;
        $display("FAIL result got %h/%b/%b want %h/%b/%b", out, out_carry, out_zero, e.d, e.c, e.z);
      end
    end
  end

  function automatic res_t model(input logic [W-1:0] a, input logic [SW-1:0] n, input logic [1:0] m);
    logic [W-1:0] r;
    logic cy;
    int k;
    k = int'(n);
    r = a;
    cy = 1'b0;
    if (k != 0) begin
      if (m == 2'b00) begin r = (a >> k) | (a << (W - k)); cy = r[W-1]; end
      else if (m == 2'b01) begin r = (a << k) | (a >> (W - k)); cy = r[0]; end
      else if (m == 2'b10) begin r = a >> k; cy = a[k-1]; end
      else begin r = $signed(a) >>> k; cy = a[k-1]; end
    end
    return {r, cy, r == '0};
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [SW-1:0] n, input logic [1:0] m);
    int t = 0;
    din = a; num = n; mode = m; in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready %b want 1", in_ready);
    end else exp_q.push_back(model(a, n, m));
    @(posedge clk); #1;
    in_valid = 0; din = 'x; num = 'x; mode = 'x;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, out, out_carry, out_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outs got v%b %h %b %b want all 0", out_valid, out, out_carry, out_zero);
    end
    @(negedge clk); rst_n = 1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    out_ready = 1;
    send(32'h8000_0001, 5'd1, 2'b00);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early out_valid %b want 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out !== 32'hC000_0000 || out_carry !== 1'b1) begin
      errors++;
      $display("FAIL latency_ror v%b %h %b want v1 c0000000 1", out_valid, out, out_carry);
    end
    send(32'h8000_0001, 5'd4, 2'b01);
    send(32'hF000_000F, 5'd4, 2'b10);
    send(32'h8000_0000, 5'd31, 2'b11);
    send(32'h0000_0001, 5'd1, 2'b10);
    drain();
  endtask

  task automatic test_num_zero();
    int p0 = popped;
    out_ready = 1;
    for (int m = 0; m < 4; m++) send(32'hDEAD_BEEF, 5'd0, 2'(m));
    drain();
    checks++;
    if (popped - p0 !== 4) begin errors++; $display("FAIL num_zero_count got %0d want 4", popped - p0); end
  endtask

  task automatic test_backpressure();
    res_t ea = model(32'h1234_5678, 5'd3, 2'b00);
    out_ready = 0;
    send(32'h1234_5678, 5'd3, 2'b00);
    send(32'h9ABC_DEF0, 5'd7, 2'b01);
    din = 32'h8F0F_0F0F; num = 5'd5; mode = 2'b11; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || {out, out_carry, out_zero} !== ea) begin
        errors++;
        $display("FAIL bp_hold got v%b %h %b want v1 %h %b", out_valid, out, out_carry, ea.d, ea.c);
      end
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready %b want 1", in_ready); end
    else exp_q.push_back(model(32'h8F0F_0F0F, 5'd5, 2'b11));
    @(posedge clk); #1;
    in_valid = 0; din = 'x; num = 'x; mode = 'x;
    drain();
  endtask

  task automatic test_stream();
    int p0 = popped;
    time t0;
    out_ready = 1;
    t0 = $time;
    for (int i = 0; i < 64; i++)
      send($urandom, SW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    checks++;
    if ($time - t0 !== 640) begin errors++; $display("FAIL stream_rate got %0t want 640", $time - t0); end
    drain();
    checks++;
    if (popped - p0 !== 64) begin errors++; $display("FAIL stream_count got %0d want 64", popped - p0); end
  endtask

  task automatic test_random_ready();
    int p0 = popped;
    rnd_en = 1;
    for (int i = 0; i < 64; i++)
      send($urandom, SW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    drain();
    rnd_en = 0;
    @(posedge clk); #2;
    out_ready = 1;
    checks++;
    if (popped - p0 !== 64) begin errors++; $display("FAIL random_count got %0d want 64", popped - p0); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    send(32'h0000_00FF, 5'd2, 2'b00);
    send(32'h0000_0F00, 5'd3, 2'b01);
    #2 rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_mid got v%b %h want v0 0", out_valid, out);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_after out_valid %b want 0", out_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    for (int n = 1; n <= 2; n++) begin
      out_ready = 0;
      for (int i = 0; i < n; i++) send(32'h1111_0000 + 32'(i), 5'd1, 2'b10);
      @(posedge clk); #1;
      flush = 1; in_valid = 1; din = 32'hCAFE_F00D; num = 5'd4; mode = 2'b00;
      @(negedge clk);
      checks++;
      if (in_ready !== (n == 1)) begin errors++; $display("FAIL flush_in_ready got %b want %b", in_ready, n == 1); end
      @(posedge clk); #1;
      flush = 0; in_valid = 0; din = 'x; num = 'x; mode = 'x;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear out_valid %b want 0", out_valid); end
      exp_q.delete();
      out_ready = 1;
      repeat (5) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after out_valid %b want 0", out_valid); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_num_zero();
    test_backpressure();
    test_stream();
    test_random_ready();
    test_reset_mid();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
